// File: rtl/drive_output_stage.sv
// drive_output_stage: fetches row/col pattern words on address change, muxes per channel, drives registered outputs with polarity and optional dead-time (macro DRIVE_OUTPUT_DEADTIME_EN); ports: clock, reset, row_select, col_select, output_active, inverter_select, row_col_select, mem_rd_en, mem_addr, mem_rd_data, drive_out, pattern_valid, fetch_busy
module drive_output_stage #(
    parameter int MEM_ADDRESS_LENGTH = 7,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    input  logic                          output_active,
    input  logic [15:0]                   inverter_select,
    input  logic [15:0]                   row_col_select,
    output logic                          mem_rd_en,
    output logic [MEM_ADDRESS_LENGTH:0]   mem_addr,
    input  logic [15:0]                   mem_rd_data,
    output logic [15:0]                   drive_out,
    output logic                          pattern_valid,
    output logic                          fetch_busy
);
    localparam int AW = MEM_ADDRESS_LENGTH;
    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead_cycles
        $error("DEAD_CYCLES must be within 1..255");
    end
    typedef enum logic [2:0] {
        IDLE,
        RD_ROW,
        RD_COL,
        LATCH
`ifdef DRIVE_OUTPUT_DEADTIME_EN
        , DEAD
`endif
    } state_t;
    state_t state, state_d;
    logic [AW-1:0] row_q, col_q, frow_q, fcol_q;
    logic first_q, pending_q, commit, chg;
    logic [15:0] row_word, next_pattern, commit_pat, pattern_q, dead_mask;
    assign chg = (row_select != row_q) || (col_select != col_q);
    assign next_pattern = (row_col_select & mem_rd_data) | (~row_col_select & row_word);
    assign fetch_busy = (state != IDLE);
`ifdef DRIVE_OUTPUT_DEADTIME_EN
    logic load_dead;
    logic [7:0] dead_cnt;
    logic [15:0] next_q;
    assign commit_pat = (state == DEAD) ? next_q : next_pattern;
    always_ff @(posedge clock) begin
        if (reset) begin
            dead_mask <= '0;
            dead_cnt <= '0;
            next_q <= '0;
        end else if (load_dead) begin
            dead_mask <= pattern_q ^ next_pattern;
            dead_cnt <= 8'(DEAD_CYCLES - 1);
            next_q <= next_pattern;
        end else if (state == DEAD) begin
            dead_cnt <= dead_cnt - 8'd1;
            dead_mask <= commit ? 16'h0 : dead_mask;
        end
    end
`else
    assign dead_mask = '0;
    assign commit_pat = next_pattern;
`endif
    always_comb begin
        state_d = state;
        mem_rd_en = 1'b0;
        mem_addr = '0;
        commit = 1'b0;
`ifdef DRIVE_OUTPUT_DEADTIME_EN
        load_dead = 1'b0;
`endif
        case (state)
            IDLE: state_d = (chg || first_q || pending_q) ? RD_ROW : IDLE;
            RD_ROW: begin
                mem_rd_en = 1'b1;
                mem_addr = {1'b0, frow_q};
                state_d = RD_COL;
            end
            RD_COL: begin
                mem_rd_en = 1'b1;
                mem_addr = {1'b1, fcol_q};
                state_d = LATCH;
            end
            LATCH: begin
                // a stale fetch is thrown away and restarted from the live address
                if (pending_q || chg) state_d = RD_ROW;
`ifdef DRIVE_OUTPUT_DEADTIME_EN
                else if (next_pattern != pattern_q) begin
                    load_dead = 1'b1;
                    state_d = DEAD;
                end
`endif
                else begin
                    commit = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef DRIVE_OUTPUT_DEADTIME_EN
            DEAD: if (dead_cnt == 8'd0) begin
                commit = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            row_q <= '0;
            col_q <= '0;
            frow_q <= '0;
            fcol_q <= '0;
            first_q <= 1'b1;
            pending_q <= 1'b0;
            row_word <= '0;
            pattern_q <= '0;
            pattern_valid <= 1'b0;
            drive_out <= '0;
        end else begin
            state <= state_d;
            row_q <= row_select;
            col_q <= col_select;
            // RD_ROW is only ever entered, never held, so state_d==RD_ROW marks entry
            if (state_d == RD_ROW) begin
                frow_q <= row_select;
                fcol_q <= col_select;
                first_q <= 1'b0;
                pending_q <= 1'b0;
            end else if (chg) begin
                pending_q <= 1'b1;
            end
            if (state == RD_COL) row_word <= mem_rd_data;
            if (commit) begin
                pattern_q <= commit_pat;
                pattern_valid <= 1'b1;
            end
            drive_out <= (pattern_q & {16{output_active}} & ~dead_mask) ^ inverter_select;
        end
    end
endmodule

// File: doc/drive_output_stage.md
DRIVE_OUTPUT_STAGE -- requirements
Module: drive_output_stage

Interface
REQ-001 The module SHALL have parameter MEM_ADDRESS_LENGTH, default 7, giving the row/column index width.
REQ-002 The module SHALL have parameter DEAD_CYCLES, default 4, giving the dead-time length in clocks (legal range 1..255).
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, with ports clock (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
- row_select, input, MEM_ADDRESS_LENGTH, current row index.
- col_select, input, MEM_ADDRESS_LENGTH, current column index.
- output_active, input, 1, drive window enable.
- inverter_select, input, 16, per-channel output polarity.
- row_col_select, input, 16, per-channel source: 0 = row word, 1 = column word.
- mem_rd_en, output, 1, pattern memory read strobe.
- mem_addr, output, MEM_ADDRESS_LENGTH+1, pattern memory address; MSB 0 = row table, 1 = column table.
- mem_rd_data, input, 16, read data valid exactly 1 cycle after mem_rd_en.
- drive_out, output, 16, registered channel drive.
- pattern_valid, output, 1, high once a pattern has been committed.
- fetch_busy, output, 1, high when the FSM is not in IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, RD_ROW, RD_COL, LATCH and DEAD.
REQ-006 Each cycle the block SHALL register row_select/col_select into addr_q; a change versus addr_q, or the post-reset first-fetch flag, SHALL form a fetch request.
REQ-007 In IDLE, a fetch request SHALL move the FSM to RD_ROW; otherwise it stays in IDLE.
REQ-008 RD_ROW SHALL assert mem_rd_en with mem_addr={0,row_q}, then go to RD_COL.
REQ-009 RD_COL SHALL assert mem_rd_en with mem_addr={1,col_q}, capture mem_rd_data as row_word, then go to LATCH.
REQ-010 LATCH SHALL capture col_word and compute, per bit i, next_pattern[i] = row_col_select[i] ? col_word[i] : row_word[i].
REQ-011 The addresses used by a fetch SHALL be frozen at RD_ROW entry.
REQ-012 If the address changes during RD_ROW, RD_COL or LATCH, a pending flag SHALL be set; at LATCH the result SHALL be discarded and the FSM SHALL go to RD_ROW, pending cleared.
REQ-013 Commit SHALL mean pattern_q <= next_pattern and pattern_valid <= 1, followed by transition to IDLE.
REQ-014 drive_out SHALL be registered each cycle as drive_out[i] = (pattern_q[i] & output_active & ~dead_mask[i]) ^ inverter_select[i].
REQ-015 Latency SHALL be 1 clock from output_active or inverter_select to drive_out.
REQ-016 With dead-time disabled, latency SHALL be 5 clocks from a new row_select/col_select value to drive_out.
REQ-017 Outside DEAD, dead_mask SHALL be 0.
REQ-018 mem_rd_en SHALL be 0 in IDLE, LATCH and DEAD.
REQ-019 fetch_busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 Reset SHALL force state=IDLE, addr_q=0, pattern_q=0, dead_mask=0, dead counter=0, pending=0, pattern_valid=0, drive_out=0, mem_rd_en=0, mem_addr=0, and set the first-fetch flag.
REQ-021 Reset asserted mid-fetch or mid-dead-time SHALL abandon the operation with no commit.
REQ-022 The first-fetch flag SHALL clear on RD_ROW entry.

Configuration
REQ-023 The dead-time feature SHALL be controlled by the macro DRIVE_OUTPUT_DEADTIME_EN.
REQ-024 With DRIVE_OUTPUT_DEADTIME_EN defined, LATCH (no pending) SHALL compute diff = pattern_q ^ next_pattern; diff=0 SHALL commit immediately.
REQ-025 With DRIVE_OUTPUT_DEADTIME_EN defined and diff nonzero, LATCH SHALL load dead_mask=diff, enter DEAD, and hold DEAD for exactly DEAD_CYCLES cycles, then commit and clear dead_mask.
REQ-026 During DEAD, changing channels SHALL sit at their inverter_select level; address changes SHALL set pending, with the refetch starting after commit.
REQ-027 Without DRIVE_OUTPUT_DEADTIME_EN, the DEAD state and dead counter SHALL not be synthesised, dead_mask SHALL be tied to 0, and LATCH SHALL always commit.

Verification
REQ-028 Reset release with row/col=0, mem row[0]=16'h00FF, col[0]=16'hFF00, row_col_select=16'hF0F0, output_active=1, inverter_select=0 -> single fetch, drive_out=16'hF00F, pattern_valid=1.
REQ-029 Set inverter_select=16'h0001 while idle -> drive_out=16'hF00E one clock later, no memory read.
REQ-030 Deassert output_active -> drive_out=inverter_select next clock; reassert -> prior pattern restored next clock.
REQ-031 Change col_select during RD_COL -> first result discarded, exactly one refetch, final pattern from the new address.
REQ-032 DEADTIME_EN, DEAD_CYCLES=4, pattern 16'h000F->16'h00F0 -> bits[7:0]=0 for 4 cycles, then 16'h00F0; bits[15:8] unaffected.
REQ-033 Assert reset during DEAD -> next cycle drive_out=0, pattern_valid=0, fetch restarts after release.
